// File: rtl/des56_pkg.sv
// des56_pkg: shared constants and helpers for the iterative DES engine.
//   - Permutation tables (IP, FP, E, P, PC1, PC2) hold 1-based DES bit numbers.
//   - S-boxes S1..S8 are stored one box per 256-bit word, row-major, MSB nibble first.
//   - Key rotation schedule, round count, FSM state type.
//   - Helper functions: bit-order mapping, table permutations, S-box lookup,
//     28-bit rotations and (with DES56_KEY_PARITY_CHECK_EN) key byte parity.
// Bit ordering: DES bit n of a w-bit vector lives at index w-n (MSB-first).
package des56_pkg;

  localparam int unsigned ROUNDS = 16;
  localparam logic [3:0]  LAST_RND = 4'(ROUNDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SHIFT_T [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  localparam logic [7:0] IP_T [0:63] = '{
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};

  localparam logic [7:0] FP_T [0:63] = '{
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
    8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
    8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
    8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};

  localparam logic [7:0] E_T [0:47] = '{
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
    8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13,
    8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21,
    8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
    8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};

  localparam logic [7:0] P_T [0:31] = '{
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};

  localparam logic [7:0] PC1_T [0:55] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};

  localparam logic [7:0] PC2_T [0:47] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};

  // Entry (row*16 + col) is the nibble at [255 - 4*idx -: 4].
  localparam logic [255:0] SBOX_T [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // DES bit n (1-based, MSB-first) of a w-bit vector; 64-n for a full block.
  function automatic int des_bit(input int n, input int w);
    return w - n;
  endfunction

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[des_bit(i + 1, 64)] = x[des_bit(int'(IP_T[i]), 64)];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[des_bit(i + 1, 64)] = x[des_bit(int'(FP_T[i]), 64)];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[des_bit(i + 1, 48)] = x[des_bit(int'(E_T[i]), 32)];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[des_bit(i + 1, 32)] = x[des_bit(int'(P_T[i]), 32)];
    return y;
  endfunction

  // Drops the eight parity bits; result is {C0, D0}.
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[des_bit(i + 1, 56)] = x[des_bit(int'(PC1_T[i]), 64)];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[des_bit(i + 1, 48)] = x[des_bit(int'(PC2_T[i]), 56)];
    return y;
  endfunction

  // Row comes from the outer bits b[5],b[0]; column from b[4:1].
  function automatic logic [3:0] sbox_lookup(input int s, input logic [5:0] b);
    logic [5:0] idx;
    int         base;
    idx  = {b[5], b[0], b[4:1]};
    base = 255 - 4 * int'(idx);
    return SBOX_T[s][base -: 4];
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

`ifdef DES56_KEY_PARITY_CHECK_EN
  // 1 when any key byte fails odd parity.
  function automatic logic key_parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (^k[8*b +: 8] == 1'b0) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

endpackage

// File: rtl/des56_round.sv
// des56_round: one combinational DES Feistel round.
//   l_i, r_i : 32-bit halves entering the round
//   k_i      : 48-bit round subkey
//   l_o, r_o : halves leaving the round (l_o = r_i, r_o = l_i ^ f(r_i, k_i))
module des56_round
  import des56_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  logic [47:0] x_s;
  logic [31:0] sb_s;

  // f-function: expand, mix key, substitute through S1..S8.
  always_comb begin
    x_s  = perm_e(r_i) ^ k_i;
    sb_s = 32'd0;
    for (int s = 0; s < 8; s++) begin
      sb_s[31 - 4*s -: 4] = sbox_lookup(s, x_s[47 - 6*s -: 6]);
    end
  end

  assign l_o = r_i;
  assign r_o = l_i ^ perm_p(sb_s);

endmodule

// File: rtl/des56_core.sv
// des56_core: iterative single-DES engine, one Feistel round per clock.
//   clk, rst            : clock, synchronous active-high reset
//   indata, inkey       : block and key (bit 63 = DES bit 1); key parity bits ignored
//   decipher            : 0 encrypt, 1 decrypt; sampled with ds at start only
//   ds                  : start strobe, honoured only when idle
//   outdata             : result, held until next completion or reset
//   rdy                 : one-cycle pulse, 16 clocks after the start edge
//   rdy_next_cycle      : high the cycle before rdy
//   rdy_next_next_cycle : high two cycles before rdy
//   key_parity_err      : key byte parity flag; only real when built with
//                         DES56_KEY_PARITY_CHECK_EN, otherwise constant 0
module des56_core
  import des56_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] indata,
  input  logic [63:0] inkey,
  input  logic        decipher,
  input  logic        ds,
  output logic [63:0] outdata,
  output logic        rdy,
  output logic        rdy_next_cycle,
  output logic        rdy_next_next_cycle,
  output logic        key_parity_err
);

  state_e      state_q, state_d;
  logic [3:0]  rnd_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        dec_q;
  logic [63:0] outdata_q;
  logic        rdy_q, rnc_q, rnn_q;
  logic        rdy_d, rnc_d, rnn_d;

  logic        start_s, step_s, done_s;
  logic [63:0] ip_s;
  logic [55:0] pc1_s;
  logic [1:0]  sh_s;
  logic [3:0]  dec_idx_s;
  logic [27:0] c_rot_s, d_rot_s;
  logic [47:0] k_s;
  logic [31:0] l_nx_s, r_nx_s;

  assign ip_s  = perm_ip(indata);
  assign pc1_s = perm_pc1(inkey);

  // Key schedule: encrypt rotates left before use; decrypt starts at K16
  // (unrotated C0/D0) and then undoes the schedule by rotating right.
  always_comb begin
    sh_s      = 2'd0;
    // 16 - rnd_q, modulo 16; only consulted for rnd_q 1..15.
    dec_idx_s = 4'd0 - rnd_q;
    if (dec_q) begin
      if (rnd_q == 4'd0) begin
        sh_s = 2'd0;
      end else begin
        sh_s = SHIFT_T[dec_idx_s];
      end
      c_rot_s = rotr28(c_q, sh_s);
      d_rot_s = rotr28(d_q, sh_s);
    end else begin
      sh_s    = SHIFT_T[rnd_q];
      c_rot_s = rotl28(c_q, sh_s);
      d_rot_s = rotl28(d_q, sh_s);
    end
    k_s = perm_pc2({c_rot_s, d_rot_s});
  end

  des56_round u_round (
    .l_i (l_q),
    .r_i (r_q),
    .k_i (k_s),
    .l_o (l_nx_s),
    .r_o (r_nx_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ds) state_d = ST_RUN;
        else    state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (rnd_q == LAST_RND) state_d = ST_IDLE;
        else                   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath enables and early-warning flags.
  always_comb begin
    start_s = 1'b0;
    step_s  = 1'b0;
    done_s  = 1'b0;
    rnn_d   = 1'b0;
    rnc_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_s = ds;
      end
      ST_RUN: begin
        step_s = 1'b1;
        done_s = (rnd_q == LAST_RND);
        rnc_d  = (rnd_q == LAST_RND - 4'd1);
        rnn_d  = (rnd_q == LAST_RND - 4'd2);
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
    rdy_d = done_s;
  end

  // Datapath: load on start, one round per step, publish result on the last round.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q     <= 4'd0;
      l_q       <= 32'd0;
      r_q       <= 32'd0;
      c_q       <= 28'd0;
      d_q       <= 28'd0;
      dec_q     <= 1'b0;
      outdata_q <= 64'd0;
      rdy_q     <= 1'b0;
      rnc_q     <= 1'b0;
      rnn_q     <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      rnc_q <= rnc_d;
      rnn_q <= rnn_d;
      if (start_s) begin
        rnd_q <= 4'd0;
        l_q   <= ip_s[63:32];
        r_q   <= ip_s[31:0];
        c_q   <= pc1_s[55:28];
        d_q   <= pc1_s[27:0];
        dec_q <= decipher;
      end else if (step_s) begin
        rnd_q <= rnd_q + 4'd1;
        l_q   <= l_nx_s;
        r_q   <= r_nx_s;
        c_q   <= c_rot_s;
        d_q   <= d_rot_s;
        // Final output uses the swapped halves R16||L16.
        if (done_s) outdata_q <= perm_fp({r_nx_s, l_nx_s});
      end
    end
  end

`ifdef DES56_KEY_PARITY_CHECK_EN
  logic par_pend_q, par_err_q;

  // Key parity captured at start, presented with rdy, cleared by the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_pend_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else if (start_s) begin
      par_pend_q <= key_parity_bad(inkey);
      par_err_q  <= 1'b0;
    end else if (done_s) begin
      par_err_q  <= par_pend_q;
    end
  end

  assign key_parity_err = par_err_q;
`else
  assign key_parity_err = 1'b0;
`endif

  assign outdata             = outdata_q;
  assign rdy                 = rdy_q;
  assign rdy_next_cycle      = rnc_q;
  assign rdy_next_next_cycle = rnn_q;

endmodule

// File: tb/tb_des56_core.sv
// tb_des56_core: directed self-checking bench for des56_core using published
// FIPS 46 test vectors, a result scoreboard and per-cycle rdy/early-warning checks.
module tb_des56_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] indata;
  logic [63:0] inkey;
  logic        decipher;
  logic        ds;
  logic [63:0] outdata;
  logic        rdy;
  logic        rdy_next_cycle;
  logic        rdy_next_next_cycle;
  logic        key_parity_err;

  localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1   = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY3  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY3F = 64'h0F339333EB6C0C72;
  localparam logic [63:0] PT3   = 64'h8787878787878787;
  localparam logic [63:0] CT3   = 64'h0000000000000000;

`ifdef DES56_KEY_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  des56_core dut (
    .clk                 (clk),
    .rst                 (rst),
    .indata              (indata),
    .inkey               (inkey),
    .decipher            (decipher),
    .ds                  (ds),
    .outdata             (outdata),
    .rdy                 (rdy),
    .rdy_next_cycle      (rdy_next_cycle),
    .rdy_next_next_cycle (rdy_next_next_cycle),
    .key_parity_err      (key_parity_err)
  );

  logic [63:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flags();
    return {61'd0, rdy, rdy_next_cycle, rdy_next_next_cycle};
  endfunction

  task automatic chk_result(input string tag);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: rdy with empty scoreboard, observed %h", tag, outdata);
    end else begin
      chk(tag, outdata, sb.pop_front());
    end
  endtask

  // One operation; inputs scrambled after the start edge. Optional second ds
  // at round inj_at (0 = none) with different data, which must be ignored.
  task automatic do_op(input string tag, input logic [63:0] key, input logic [63:0] data,
                       input logic dec, input logic [63:0] exp_out, input logic exp_err,
                       input int inj_at, input logic [63:0] inj_data);
    logic [63:0] exp_fl;
    @(negedge clk);
    inkey = key; indata = data; decipher = dec; ds = 1'b1;
    sb.push_back(exp_out);
    @(negedge clk);
    ds = 1'b0; indata = ~data; inkey = ~key; decipher = ~dec;
    for (int k = 1; k <= 18; k++) begin
      ds = (k == inj_at);
      if (k == inj_at) indata = inj_data;
      @(negedge clk);
      exp_fl = {61'd0, (k == 16), (k == 15), (k == 14)};
      chk($sformatf("%s flags k=%0d", tag, k), flags(), exp_fl);
      if (k == 16) begin
        chk_result($sformatf("%s outdata", tag));
        chk($sformatf("%s parity", tag), {63'd0, key_parity_err}, {63'd0, exp_err});
      end
      if (k == 18) begin
        chk($sformatf("%s hold", tag), outdata, exp_out);
        chk($sformatf("%s parity hold", tag), {63'd0, key_parity_err}, {63'd0, exp_err});
      end
    end
    ds = 1'b0;
  endtask

  int n_rdy;

  initial begin
    rst = 1'b1; ds = 1'b0; indata = 64'd0; inkey = 64'd0; decipher = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outdata", outdata, 64'd0);
    chk("reset flags", flags(), 64'd0);
    chk("reset parity", {63'd0, key_parity_err}, 64'd0);
    rst = 1'b0;

    do_op("t1 enc", KEY1, PT1, 1'b0, CT1, 1'b0, 0, 64'd0);
    do_op("t2 dec", KEY1, CT1, 1'b1, PT1, 1'b0, 0, 64'd0);
    do_op("t3 enc", KEY3, PT3, 1'b0, CT3, 1'b0, 0, 64'd0);
    do_op("t3 flipped parity", KEY3F, PT3, 1'b0, CT3, PAR_EN, 0, 64'd0);
    do_op("t6 ds mid-op", KEY1, PT1, 1'b0, CT1, 1'b0, 5, PT3);

    // Reset during round 8 aborts the operation.
    @(negedge clk);
    inkey = KEY1; indata = PT1; decipher = 1'b0; ds = 1'b1;
    @(negedge clk);
    ds = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 outdata after rst", outdata, 64'd0);
    n_rdy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy) n_rdy++;
    end
    chk("t5 no rdy after abort", 64'(n_rdy), 64'd0);
    chk("t5 outdata held zero", outdata, 64'd0);
    // Reset and start on the same edge: reset wins.
    rst = 1'b1; ds = 1'b1;
    @(negedge clk);
    rst = 1'b0; ds = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy) n_rdy++;
    end
    chk("t5 rst overrides ds", 64'(n_rdy), 64'd0);
    do_op("t5 after reset", KEY1, PT1, 1'b0, CT1, 1'b0, 0, 64'd0);

    // ds held high: restart on the rdy cycle, one block per 17 clocks.
    @(negedge clk);
    inkey = KEY1; indata = PT1; decipher = 1'b0; ds = 1'b1;
    sb.push_back(CT1);
    n_rdy = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        inkey = KEY3; indata = PT3; decipher = 1'b0;
        sb.push_back(CT3);
      end
      if (k == 17) begin
        inkey = KEY1; indata = CT1; decipher = 1'b1;
        sb.push_back(PT1);
      end
      if (k == 34) begin
        inkey = KEY3F; indata = PT1; decipher = 1'b0;
      end
      chk($sformatf("t4 flags k=%0d", k), flags(),
          {61'd0, (k % 17 == 16), (k % 17 == 15), (k % 17 == 14)});
      if (rdy) begin
        n_rdy++;
        chk_result($sformatf("t4 block %0d", n_rdy));
      end
    end
    ds = 1'b0;
    chk("t4 rdy pulse count", 64'(n_rdy), 64'd3);
    chk("t4 scoreboard drained", 64'(sb.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4 outdata after rst", outdata, 64'd0);
    chk("t4 flags after rst", flags(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
